// File: rtl/router_src_arbiter.sv
// Round-robin, packet-atomic arbiter that shares the router ingress among NUM_SRC sources.
// Define ARB_PARITY_GEN_EN to generate the parity byte here instead of popping it from the source.
module router_src_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int GAP_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_SRC-1:0]   src_req,
    input  logic [NUM_SRC*8-1:0] src_data,
    output logic [NUM_SRC-1:0]   src_rd,
    input  logic                 busy,
    output logic [7:0]           data_in,
    output logic                 pkt_valid,
    output logic [NUM_SRC-1:0]   grant,
    output logic                 pkt_done,
    output logic                 bad_addr
);
    localparam int IDX_W = $clog2(NUM_SRC);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PLD, S_PAR, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [5:0]         len_q, len_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [3:0]         gap_q, gap_d;
    logic               done_q, done_d;
`ifdef ARB_PARITY_GEN_EN
    logic [7:0]         par_q, par_d;
`endif

    logic [NUM_SRC-1:0][7:0] src_bytes;
    logic [7:0]              head;
    logic                    xfer;
    logic [IDX_W-1:0]        pick;
    logic [IDX_W-1:0]        cand;

    assign src_bytes = src_data;
    assign head      = src_bytes[win_q];
    assign xfer      = ~busy;
    assign grant     = grant_q;
    assign pkt_done  = done_q;

    // Scan downwards so the requester nearest after last_q is written last and wins.
    always_comb begin
        pick = last_q;
        cand = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = IDX_W'((int'(last_q) + k) % NUM_SRC);
            if (src_req[cand]) pick = cand;
        end
    end

    // NOTE: every output and next-state signal gets a default before the case, so no latches.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        win_d     = win_q;
        last_d    = last_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        done_d    = 1'b0;
        src_rd    = '0;
        data_in   = 8'h00;
        pkt_valid = 1'b0;
        bad_addr  = 1'b0;
`ifdef ARB_PARITY_GEN_EN
        par_d     = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (|src_req) begin
                    win_d   = pick;
                    grant_d = NUM_SRC'(1) << pick;
                    state_d = S_HDR;
`ifdef ARB_PARITY_GEN_EN
                    par_d   = 8'h00;
`endif
                end
            end
            S_HDR: begin
                pkt_valid = 1'b1;
                data_in   = head;
                if (xfer) begin
                    src_rd   = grant_q;
                    len_d    = head[7:2];
                    cnt_d    = 6'd0;
                    bad_addr = (head[1:0] == 2'b11);
                    state_d  = (head[7:2] != 6'd0) ? S_PLD : S_PAR;
`ifdef ARB_PARITY_GEN_EN
                    par_d    = par_q ^ head;
`endif
                end
            end
            S_PLD: begin
                pkt_valid = 1'b1;
                data_in   = head;
                if (xfer) begin
                    src_rd = grant_q;
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == len_q - 6'd1) state_d = S_PAR;
`ifdef ARB_PARITY_GEN_EN
                    par_d  = par_q ^ head;
`endif
                end
            end
            S_PAR: begin
`ifdef ARB_PARITY_GEN_EN
                data_in = par_q;
`else
                data_in = head;
`endif
                if (xfer) begin
`ifndef ARB_PARITY_GEN_EN
                    src_rd = grant_q;
`endif
                    done_d  = 1'b1;
                    last_d  = win_q;
                    grant_d = '0;
                    gap_d   = 4'd0;
                    state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == 4'(GAP_CYCLES - 1)) state_d = S_IDLE;
                else                             gap_d   = gap_q + 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            win_q   <= '0;
            last_q  <= IDX_W'(NUM_SRC - 1);
            len_q   <= 6'd0;
            cnt_q   <= 6'd0;
            gap_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            win_q   <= win_d;
            last_q  <= last_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
        end
    end

`ifdef ARB_PARITY_GEN_EN
    always_ff @(posedge clock) begin
        if (reset) par_q <= 8'h00;
        else       par_q <= par_d;
    end
`endif

endmodule

// File: tb/tb_router_src_arbiter.sv
// Bench for router_src_arbiter: a directed vector table, hand-written corner sequences,
// and random traffic checked cycle by cycle against a packet-level reference model.
module tb_router_src_arbiter;
    localparam int NS  = 3;
    localparam int GAP = 1;
`ifdef ARB_PARITY_GEN_EN
    localparam bit GEN = 1'b1;
`else
    localparam bit GEN = 1'b0;
`endif
    localparam logic [2:0] PRD = GEN ? 3'b000 : 3'b001;

    logic            clock = 1'b0;
    logic            reset;
    logic [NS-1:0]   src_req;
    logic [NS*8-1:0] src_data;
    logic [NS-1:0]   src_rd;
    logic            busy;
    logic [7:0]      data_in;
    logic            pkt_valid;
    logic [NS-1:0]   grant;
    logic            pkt_done;
    logic            bad_addr;

    router_src_arbiter #(.NUM_SRC(NS), .GAP_CYCLES(GAP)) dut (
        .clock(clock), .reset(reset), .src_req(src_req), .src_data(src_data),
        .src_rd(src_rd), .busy(busy), .data_in(data_in), .pkt_valid(pkt_valid),
        .grant(grant), .pkt_done(pkt_done), .bad_addr(bad_addr)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Source byte queues (what each source pops) and expected router streams per source.
    logic [7:0] sq[NS][$];
    logic [7:0] exp_pkts[NS][$];
    logic [7:0] cur_pkt[$];

    logic [NS-1:0] m_grant;
    int m_owner, m_pos, m_len, m_last, m_gap;
    bit m_done;

    bit sb_en;
    int busy_mode, stall_left;
    int cnt_rd, cnt_pv, cnt_done, cnt_xfer, cnt_bad;
    logic [NS-1:0] prev_grant;
    int dut_order[$];

    function automatic bit src_complete(input int s);
        logic [7:0] h;
        if (sq[s].size() == 0) return 1'b0;
        h = sq[s][0];
        return sq[s].size() >= int'(h[7:2]) + (GEN ? 1 : 2);
    endfunction

    task automatic add_pkt(input int s, input logic [7:0] hdr);
        logic [7:0] p, b;
        p = hdr;
        exp_pkts[s].push_back(hdr);
        sq[s].push_back(hdr);
        for (int i = 0; i < int'(hdr[7:2]); i++) begin
            b = 8'($urandom);
            p ^= b;
            exp_pkts[s].push_back(b);
            sq[s].push_back(b);
        end
        exp_pkts[s].push_back(p);
        if (!GEN) sq[s].push_back(p);
    endtask

    task automatic model_reset();
        m_grant = '0; m_last = NS - 1; m_gap = 0; m_done = 1'b0; m_pos = 0; m_len = 0;
        cur_pkt.delete();
        for (int s = 0; s < NS; s++) begin
            sq[s].delete();
            exp_pkts[s].delete();
        end
    endtask

    function automatic bit pending();
        bit p;
        p = (m_grant != 0) || (m_gap > 0) || m_done;
        for (int s = 0; s < NS; s++) if (exp_pkts[s].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic model_step();
        logic [NS-1:0] eg, er;
        logic [7:0] ed, h;
        logic ev, eb;
        int w;
        eg = m_grant;
        ev = (eg != 0) && (m_pos <= m_len);
        ed = (eg != 0) ? cur_pkt[m_pos] : 8'h00;
        er = ((eg != 0) && !busy && (m_pos <= m_len || !GEN)) ? eg : '0;
        eb = (eg != 0) && !busy && (m_pos == 0) && (ed[1:0] == 2'b11);
        check("grant", grant, eg);
        check("pkt_valid", pkt_valid, ev);
        check("data_in", data_in, ed);
        check("src_rd", src_rd, er);
        check("bad_addr", bad_addr, eb);
        check("pkt_done", pkt_done, m_done);
        m_done = 1'b0;
        if (eg == 0) begin
            if (m_gap > 0) m_gap--;
            else if (src_req != 0) begin
                w = -1;
                for (int k = 1; k <= NS; k++)
                    if (w < 0 && src_req[(m_last + k) % NS]) w = (m_last + k) % NS;
                check("pick_has_pkt", exp_pkts[w].size() > 0, 1);
                if (exp_pkts[w].size() > 0) begin
                    h = exp_pkts[w][0];
                    m_owner = w; m_grant = NS'(1) << w; m_pos = 0; m_len = int'(h[7:2]);
                    cur_pkt.delete();
                    for (int i = 0; i < m_len + 2; i++) cur_pkt.push_back(exp_pkts[w].pop_front());
                end
            end
        end else if (!busy) begin
            if (m_pos == m_len + 1) begin
                m_grant = '0; m_last = m_owner; m_gap = GAP; m_done = 1'b1;
            end else m_pos++;
        end
    endtask

    task automatic tick();
        @(negedge clock);
        for (int s = 0; s < NS; s++) begin
            src_data[s*8 +: 8] = (sq[s].size() > 0) ? sq[s][0] : 8'h00;
            src_req[s] = src_complete(s);
        end
        case (busy_mode)
            0: busy = 1'b0;
            1: busy = ($urandom_range(0, 3) == 0);
            2: begin
                busy = (m_grant != 0) && (m_pos == 3) && (stall_left > 0);
                if (busy) stall_left--;
            end
            default: busy = 1'b1;
        endcase
        #1;
        if (reset) begin
            model_reset();
            prev_grant = '0;
        end else begin
            if (sb_en) model_step();
            if (|src_rd) cnt_rd++;
            if (pkt_valid) cnt_pv++;
            if (pkt_done) cnt_done++;
            if (bad_addr) cnt_bad++;
            if ((|grant) && !busy) cnt_xfer++;
            if (grant != 0 && prev_grant == 0)
                for (int i = 0; i < NS; i++) if (grant[i]) dut_order.push_back(i);
            prev_grant = grant;
            for (int s = 0; s < NS; s++)
                if (src_rd[s] && sq[s].size() > 0) void'(sq[s].pop_front());
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic clear_counts();
        cnt_rd = 0; cnt_pv = 0; cnt_done = 0; cnt_xfer = 0; cnt_bad = 0;
        dut_order.delete();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", pending(), 0);
    endtask

    typedef struct {
        logic [2:0] req;
        logic [7:0] d0;
        logic       b;
        logic [2:0] g;
        logic       pv;
        logic [7:0] din;
        logic [2:0] rd;
        logic       dn;
        logic       ba;
    } vec_t;

    vec_t vt[13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] hdr;
        // len0 header then len3/addr3 header from src 0, with one busy stall in the payload
        vt[0]  = '{3'b001, 8'h01, 1'b0, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0};
        vt[1]  = '{3'b001, 8'h01, 1'b0, 3'b001, 1'b1, 8'h01, 3'b001, 1'b0, 1'b0};
        vt[2]  = '{3'b000, 8'h01, 1'b0, 3'b001, 1'b0, 8'h01, PRD,    1'b0, 1'b0};
        vt[3]  = '{3'b000, 8'h00, 1'b0, 3'b000, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0};
        vt[4]  = '{3'b001, 8'h0F, 1'b0, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0};
        vt[5]  = '{3'b001, 8'h0F, 1'b0, 3'b001, 1'b1, 8'h0F, 3'b001, 1'b0, 1'b1};
        vt[6]  = '{3'b000, 8'hA1, 1'b1, 3'b001, 1'b1, 8'hA1, 3'b000, 1'b0, 1'b0};
        vt[7]  = '{3'b000, 8'hA1, 1'b0, 3'b001, 1'b1, 8'hA1, 3'b001, 1'b0, 1'b0};
        vt[8]  = '{3'b000, 8'hB2, 1'b0, 3'b001, 1'b1, 8'hB2, 3'b001, 1'b0, 1'b0};
        vt[9]  = '{3'b000, 8'hC3, 1'b0, 3'b001, 1'b1, 8'hC3, 3'b001, 1'b0, 1'b0};
        vt[10] = '{3'b000, 8'hDF, 1'b0, 3'b001, 1'b0, 8'hDF, PRD,    1'b0, 1'b0};
        vt[11] = '{3'b000, 8'h00, 1'b0, 3'b000, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0};
        vt[12] = '{3'b000, 8'h00, 1'b0, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0};

        reset = 1'b1; busy = 1'b1; src_req = '0; src_data = '0;
        sb_en = 1'b1; busy_mode = 0; stall_left = 0;
        clear_counts();
        do_reset();

        sb_en = 1'b0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clock);
            src_req = vt[i].req;
            src_data = {16'h0000, vt[i].d0};
            busy = vt[i].b;
            #1;
            check($sformatf("vec%0d_grant", i), grant, vt[i].g);
            check($sformatf("vec%0d_pkt_valid", i), pkt_valid, vt[i].pv);
            check($sformatf("vec%0d_data_in", i), data_in, vt[i].din);
            check($sformatf("vec%0d_src_rd", i), src_rd, vt[i].rd);
            check($sformatf("vec%0d_pkt_done", i), pkt_done, vt[i].dn);
            check($sformatf("vec%0d_bad_addr", i), bad_addr, vt[i].ba);
        end
        sb_en = 1'b1;

        // single source, one 8'h16 packet
        do_reset();
        clear_counts();
        add_pkt(0, 8'h16);
        drain(100);
        check("t1_pops", cnt_rd, GEN ? 6 : 7);
        check("t1_valid_cycles", cnt_pv, 6);
        check("t1_done", cnt_done, 1);
        check("t1_bytes", cnt_xfer, 7);
        check("t1_grants", dut_order.size(), 1);
        if (dut_order.size() > 0) check("t1_owner", dut_order[0], 0);

        // all three requesting: round-robin order from reset
        do_reset();
        clear_counts();
        add_pkt(0, 8'h16); add_pkt(0, 8'h16); add_pkt(1, 8'h16); add_pkt(2, 8'h16);
        drain(200);
        check("t2_grants", dut_order.size(), 4);
        if (dut_order.size() == 4) begin
            check("t2_order0", dut_order[0], 0);
            check("t2_order1", dut_order[1], 1);
            check("t2_order2", dut_order[2], 2);
            check("t2_order3", dut_order[3], 0);
        end

        // two-cycle stall on payload byte 3
        clear_counts();
        busy_mode = 2; stall_left = 2;
        add_pkt(0, 8'h16);
        drain(100);
        busy_mode = 0;
        check("t3_stall_used", stall_left, 0);
        check("t3_bytes", cnt_xfer, 7);
        check("t3_pops", cnt_rd, GEN ? 6 : 7);

        // len0 packet then len3/addr3 packet
        clear_counts();
        add_pkt(1, 8'h01); add_pkt(1, 8'h0F);
        drain(100);
        check("t4_bytes", cnt_xfer, 7);
        check("t4_bad_addr", cnt_bad, 1);
        check("t4_done", cnt_done, 2);

        // reset in the middle of a src 1 payload
        do_reset();
        add_pkt(1, 8'h16);
        n = 0;
        while (!(m_grant == 3'b010 && m_pos == 2) && n < 30) begin
            tick();
            n++;
        end
        check("t5_reached_pld", (m_grant == 3'b010) && (m_pos == 2), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_counts();
        add_pkt(0, 8'h16); add_pkt(1, 8'h16);
        tick();
        check("t5_grant_after_reset", grant, 0);
        check("t5_valid_after_reset", pkt_valid, 0);
        check("t5_rd_after_reset", src_rd, 0);
        check("t5_data_after_reset", data_in, 0);
        drain(200);
        check("t5_grants", dut_order.size(), 2);
        if (dut_order.size() == 2) begin
            check("t5_first", dut_order[0], 0);
            check("t5_second", dut_order[1], 1);
        end

        // random traffic and random back-pressure
        busy_mode = 1;
        for (int c = 0; c < 400; c++) begin
            for (int s = 0; s < NS; s++) begin
                if (sq[s].size() == 0 && $urandom_range(0, 3) == 0) begin
                    hdr = {6'($urandom_range(0, 6)), 2'($urandom_range(0, 3))};
                    add_pkt(s, hdr);
                end
            end
            tick();
        end
        drain(500);
        busy_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
